// File: rtl/data_router_req_gen.sv
// Request sequencer for the data router: waits for each block, then sweeps the buffer in RR/BR/RP order.
// Compile with DATA_ROUTER_REQ_STRIDE_EN defined to enable the STRIDE column step in RP mode.
module data_router_req_gen #(
    parameter int POY    = 3,
    parameter int BUFW   = 32,
    parameter int BUFH   = 3,
    parameter int STRIDE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [7:0]  nblk,
    input  logic        blkend,
    output logic [7:0]  bank,
    output logic [7:0]  row,
    output logic [27:0] col,
    output logic [1:0]  rpsel,
    output logic        dvld,
    output logic [7:0]  dbank,
    output logic [7:0]  drow,
    output logic [27:0] dcol,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_DRAIN} state_e;
    typedef enum logic [1:0] {M_RR = 2'b00, M_BR = 2'b01, M_RP = 2'b10, M_NE = 2'b11} mode_e;

    localparam int BKW = (POY  > 1) ? $clog2(POY)  : 1;
    localparam int RWW = (BUFH > 1) ? $clog2(BUFH) : 1;
    localparam int CLW = (BUFW > 1) ? $clog2(BUFW) : 1;
    localparam int SW  = $clog2(BUFW + STRIDE) + 1;

`ifdef DATA_ROUTER_REQ_STRIDE_EN
    localparam int STEP = STRIDE;
`else
    localparam int STEP = 1;
`endif

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [7:0]       blk_cnt_q, blk_cnt_d;
    logic             pend_q, pend_d;
    logic [BKW-1:0]   bank_cnt_q, bank_cnt_d;
    logic [RWW-1:0]   row_cnt_q, row_cnt_d;
    logic [CLW-1:0]   col_cnt_q, col_cnt_d;
    logic             req_vld_q, req_vld_d;
    logic [7:0]       bank_q, bank_d, dbank_q, dbank_d;
    logic [7:0]       row_q, row_d, drow_q, drow_d;
    logic [27:0]      col_q, col_d, dcol_q, dcol_d;
    logic [1:0]       rpsel_q, rpsel_d;
    logic             dvld_q, dvld_d;
    logic             busy_q, busy_d;
    logic             fin_q, fin_d;
    logic             done_q, done_d;
    logic [1:0]       err_q, err_d;

    logic [SW-1:0]    col_sum;
    logic             row_last, bank_last, col_last, sweep_last;

    always_comb begin
        col_sum   = SW'(col_cnt_q) + SW'(STEP);
        row_last  = (row_cnt_q == RWW'(BUFH - 1));
        bank_last = (bank_cnt_q == BKW'(POY - 1));
        col_last  = (col_sum >= SW'(BUFW));
        case (mode_q)
            M_BR:    sweep_last = bank_last && row_last;
            M_RP:    sweep_last = row_last && col_last;
            default: sweep_last = row_last;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        mode_d     = mode_q;
        blk_cnt_d  = blk_cnt_q;
        pend_d     = pend_q;
        bank_cnt_d = bank_cnt_q;
        row_cnt_d  = row_cnt_q;
        col_cnt_d  = col_cnt_q;
        err_d      = err_q;
        req_vld_d  = 1'b0;
        bank_d     = '0;
        row_d      = '0;
        col_d      = '0;
        rpsel_d    = M_RR;
        fin_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (mode == M_NE) begin
                        err_d[0] = 1'b1;
                    end else begin
                        state_d    = S_WAIT;
                        mode_d     = mode_e'(mode);
                        blk_cnt_d  = (nblk == 8'd0) ? 8'd0 : nblk - 8'd1;
                        err_d      = 2'b00;
                        pend_d     = 1'b0;
                        bank_cnt_d = '0;
                        row_cnt_d  = '0;
                        col_cnt_d  = '0;
                    end
                end
            end
            S_WAIT: begin
                if (blkend || pend_q) begin
                    state_d = S_ISSUE;
                    // A fresh blkend arriving while a pending one is consumed stays pending.
                    pend_d  = pend_q && blkend;
                end
            end
            S_ISSUE: begin
                req_vld_d = 1'b1;
                bank_d    = 8'(bank_cnt_q);
                row_d     = 8'(row_cnt_q);
                col_d     = 28'(col_cnt_q);
                rpsel_d   = mode_q;
                case (mode_q)
                    M_BR: begin
                        if (row_last) begin
                            row_cnt_d  = '0;
                            bank_cnt_d = bank_cnt_q + BKW'(1);
                        end else begin
                            row_cnt_d  = row_cnt_q + RWW'(1);
                        end
                    end
                    M_RP: begin
                        if (col_last) begin
                            col_cnt_d = '0;
                            row_cnt_d = row_cnt_q + RWW'(1);
                        end else begin
                            col_cnt_d = CLW'(col_sum);
                        end
                    end
                    default: row_cnt_d = row_cnt_q + RWW'(1);
                endcase
                if (sweep_last) begin
                    bank_cnt_d = '0;
                    row_cnt_d  = '0;
                    col_cnt_d  = '0;
                    if (blk_cnt_q != 8'd0) begin
                        blk_cnt_d = blk_cnt_q - 8'd1;
                        state_d   = S_WAIT;
                    end else begin
                        state_d   = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
                fin_d   = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q == S_ISSUE || state_q == S_DRAIN) && blkend) begin
            if (pend_q) err_d[1] = 1'b1;
            else        pend_d   = 1'b1;
        end

        // The router registers each request, so its data trails the request bus by one cycle.
        dvld_d  = req_vld_q;
        dbank_d = bank_q;
        drow_d  = row_q;
        dcol_d  = col_q;
        busy_d  = (state_q != S_IDLE);
        done_d  = fin_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= M_RR;
            blk_cnt_q  <= '0;
            pend_q     <= 1'b0;
            bank_cnt_q <= '0;
            row_cnt_q  <= '0;
            col_cnt_q  <= '0;
            req_vld_q  <= 1'b0;
            bank_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            rpsel_q    <= M_RR;
            dvld_q     <= 1'b0;
            dbank_q    <= '0;
            drow_q     <= '0;
            dcol_q     <= '0;
            busy_q     <= 1'b0;
            fin_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            blk_cnt_q  <= blk_cnt_d;
            pend_q     <= pend_d;
            bank_cnt_q <= bank_cnt_d;
            row_cnt_q  <= row_cnt_d;
            col_cnt_q  <= col_cnt_d;
            req_vld_q  <= req_vld_d;
            bank_q     <= bank_d;
            row_q      <= row_d;
            col_q      <= col_d;
            rpsel_q    <= rpsel_d;
            dvld_q     <= dvld_d;
            dbank_q    <= dbank_d;
            drow_q     <= drow_d;
            dcol_q     <= dcol_d;
            busy_q     <= busy_d;
            fin_q      <= fin_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bank  = bank_q;
    assign row   = row_q;
    assign col   = col_q;
    assign rpsel = rpsel_q;
    assign dvld  = dvld_q;
    assign dbank = dbank_q;
    assign drow  = drow_q;
    assign dcol  = dcol_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_data_router_req_gen.sv
// Directed self-checking bench for data_router_req_gen; expected sweeps come from a small loop-nest model.
// Honours DATA_ROUTER_REQ_STRIDE_EN to pick the expected RP column step.
module tb_data_router_req_gen;

    localparam int POY    = 3;
    localparam int BUFW   = 32;
    localparam int BUFH   = 3;
    localparam int STRIDE = 2;
`ifdef DATA_ROUTER_REQ_STRIDE_EN
    localparam int STEP = STRIDE;
`else
    localparam int STEP = 1;
`endif

    logic        clk, rst_n, start, blkend;
    logic [1:0]  mode;
    logic [7:0]  nblk;
    logic [7:0]  bank, row, dbank, drow;
    logic [27:0] col, dcol;
    logic [1:0]  rpsel, err;
    logic        dvld, busy, done;

    data_router_req_gen #(.POY(POY), .BUFW(BUFW), .BUFH(BUFH), .STRIDE(STRIDE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .nblk(nblk), .blkend(blkend),
        .bank(bank), .row(row), .col(col), .rpsel(rpsel), .dvld(dvld),
        .dbank(dbank), .drow(drow), .dcol(dcol), .busy(busy), .done(done), .err(err)
    );

    wire [94:0] all_outs = {bank, row, col, rpsel, dvld, dbank, drow, dcol, busy, done, err};

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [43:0] got_q[$];
    logic [43:0] req_q[$];
    logic [43:0] exp_q[$];
    int          got_cyc[$];
    logic [43:0] prev_req;
    logic [1:0]  prev_rpsel;
    logic [1:0]  exp_mode;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Observe one sample per cycle, shortly after the rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (dvld) begin
            got_q.push_back({dbank, drow, dcol});
            req_q.push_back(prev_req);
            got_cyc.push_back(cyc);
            check("rpsel", prev_rpsel, exp_mode);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_req   = {bank, row, col};
        prev_rpsel = rpsel;
    end

    task automatic clear_mon();
        got_q.delete();
        req_q.delete();
        got_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic build_exp(input logic [1:0] m, input int nb);
        exp_q.delete();
        for (int k = 0; k < nb; k++) begin
            case (m)
                2'b00: for (int r = 0; r < BUFH; r++) exp_q.push_back({8'd0, 8'(r), 28'd0});
                2'b01: for (int b = 0; b < POY; b++)
                           for (int r = 0; r < BUFH; r++) exp_q.push_back({8'(b), 8'(r), 28'd0});
                default: for (int r = 0; r < BUFH; r++)
                           for (int c = 0; c < BUFW; c += STEP) exp_q.push_back({8'd0, 8'(r), 28'(c)});
            endcase
        end
    endtask

    task automatic do_start(input logic [1:0] m, input logic [7:0] n);
        start = 1'b1;
        mode  = m;
        nblk  = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_blkend(output int at);
        at     = cyc;
        blkend = 1'b1;
        @(negedge clk);
        blkend = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic verify(input string name, input int exp_gaps);
        int gaps;
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_tag%0d", name, i), got_q[i], exp_q[i]);
            check($sformatf("%s_req%0d", name, i), req_q[i], exp_q[i]);
        end
        gaps = 0;
        for (int i = 1; i < got_cyc.size(); i++)
            if (got_cyc[i] - got_cyc[i-1] != 1) gaps++;
        check({name, "_gaps"}, gaps, exp_gaps);
        check({name, "_done_cnt"}, done_cnt, 1);
        if (got_cyc.size() > 0) check({name, "_done_lag"}, done_cyc, got_cyc[got_cyc.size()-1] + 1);
        check({name, "_busy_end"}, busy, 0);
    endtask

    initial begin
        int bc, dummy;
        rst_n  = 1'b0;
        start  = 1'b0;
        blkend = 1'b0;
        mode   = 2'b00;
        nblk   = 8'd0;
        exp_mode = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_outs", all_outs, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_outs", all_outs, 0);

        // RR, one block, blkend ten cycles after start
        clear_mon();
        exp_mode = 2'b00;
        build_exp(2'b00, 1);
        do_start(2'b00, 8'd1);
        @(negedge clk);
        check("t1_busy", busy, 1);
        repeat (8) @(negedge clk);
        pulse_blkend(bc);
        wait_done(50);
        verify("t1", 0);
        if (got_cyc.size() > 0) check("t1_first_lat", got_cyc[0], bc + 3);
        check("t1_err", err, 0);

        // BR, two blocks, blkends far apart
        clear_mon();
        exp_mode = 2'b01;
        build_exp(2'b01, 2);
        do_start(2'b01, 8'd2);
        repeat (2) @(negedge clk);
        pulse_blkend(bc);
        repeat (100) @(negedge clk);
        pulse_blkend(bc);
        wait_done(100);
        verify("t2", 1);

        // RP, one block
        clear_mon();
        exp_mode = 2'b10;
        build_exp(2'b10, 1);
        do_start(2'b10, 8'd1);
        repeat (2) @(negedge clk);
        pulse_blkend(bc);
        wait_done(300);
        verify("t3", 0);

        // BR, extra blkends during block 1: one goes pending, one overflows
        clear_mon();
        exp_mode = 2'b01;
        build_exp(2'b01, 2);
        do_start(2'b01, 8'd2);
        repeat (2) @(negedge clk);
        pulse_blkend(bc);
        @(negedge clk);
        pulse_blkend(dummy);
        @(negedge clk);
        pulse_blkend(dummy);
        wait_done(100);
        verify("t4", 1);
        if (got_cyc.size() >= 10) check("t4_wait_gap", got_cyc[9] - got_cyc[8], 2);
        check("t4_err", err, 2'b10);

        // illegal mode, then a legal start with nblk=0
        do_start(2'b11, 8'd1);
        repeat (2) @(negedge clk);
        check("t5_err_ill", err, 2'b11);
        check("t5_busy_ill", busy, 0);
        clear_mon();
        exp_mode = 2'b00;
        build_exp(2'b00, 1);
        do_start(2'b00, 8'd0);
        check("t5_err_clr", err, 0);
        repeat (2) @(negedge clk);
        pulse_blkend(bc);
        wait_done(50);
        verify("t5", 0);

        // asynchronous reset in the middle of an RP sweep
        clear_mon();
        exp_mode = 2'b10;
        do_start(2'b10, 8'd1);
        repeat (2) @(negedge clk);
        pulse_blkend(bc);
        repeat (20) @(negedge clk);
        check("t6_busy_mid", busy, 1);
        #2 rst_n = 1'b0;
        #1 check("t6_rst_outs", all_outs, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        build_exp(2'b10, 1);
        do_start(2'b10, 8'd1);
        repeat (2) @(negedge clk);
        pulse_blkend(bc);
        wait_done(300);
        verify("t6", 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_router_req_gen.md
# data_router_req_gen

Command-side sequencer for the data router: drives the `bank`/`row`/`col`/`rpsel` request bus and consumes `blkend`. It waits for each input block to land in the router buffer, then sweeps that buffer in one of three read modes and tags the returning router data for the PE array. It sits between the layer controller (`start`/`done`) and the data router, and loops over `nblk` blocks per start.

## Interface
- `POY`, default 3: router banks
- `BUFW`, default 32: columns per buffer row
- `BUFH`, default 3: rows per bank
- `STRIDE`, default 1: column step in RP mode; legal range 1..BUFW
- `clk` input 1: clock; single clock domain
- `rst_n` input 1: reset, asynchronous, active-low
- `start` input 1: one-cycle pulse; sampled only in IDLE
- `mode` input 2: sweep mode, sampled with `start`; 00 = RR, 01 = BR, 10 = RP, 11 = illegal
- `nblk` input 8: number of blocks, sampled with `start`; 0 is treated as 1
- `blkend` input 1: one-cycle pulse from the router; the block buffer is full
- `bank` output 8: request bank
- `row` output 8: request row
- `col` output 28: request column
- `rpsel` output 2: request select; same encoding as `mode`
- `dvld` output 1: router data output is valid this cycle
- `dbank` output 8, `drow` output 8, `dcol` output 28: tags for the data under `dvld`
- `busy` output 1: high in any state other than IDLE
- `done` output 1: one-cycle pulse after the last sweep of the last block
- `err` output 2: sticky error flags; bit0 = illegal mode, bit1 = blkend overflow; cleared only by an accepted `start`

## Operation
- States: IDLE, WAIT, ISSUE, DRAIN.
  - IDLE -> WAIT on `start` with a legal mode.
  - `start` with mode 11: set `err[0]`, stay in IDLE.
- WAIT: on `blkend`, or if the pending flag is set, go to ISSUE. Entering ISSUE clears the pending flag.
- ISSUE: one request per cycle. `rpsel` = mode throughout.
  - RR: `row` = 0..BUFH-1; `bank` = 0, `col` = 0. BUFH requests.
  - BR: `bank` outer loop 0..POY-1, `row` inner loop 0..BUFH-1. POY*BUFH requests.
  - RP: `row` outer loop 0..BUFH-1, `col` inner loop 0, S, 2S.. while < BUFW. BUFH*ceil(BUFW/S) requests. S = STRIDE if the macro is compiled in, else S = 1.
- After the last request:
  - If blocks remain, decrement the block counter and go to WAIT.
  - Otherwise go to DRAIN.
- DRAIN: one cycle so the final `dvld` retires. Then pulse `done` and return to IDLE.
- `blkend` during ISSUE or DRAIN sets the one-deep pending flag.
  - A second `blkend` while the flag is set sets `err[1]`; that pulse is dropped.
  - `blkend` in IDLE is ignored.
- Idle bus: `rpsel` = RR, `bank`/`row`/`col` = 0. This is a harmless reload; the NE code is never driven.
- Counters are sized to the parameters. All outputs are zero-extended to port width.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, except `rpsel` = 00. State = IDLE, block counter 0, pending flag 0.
- `start` at edge N -> `busy` = 1 from edge N+1.
- `blkend` sampled high at edge M in WAIT -> first request is valid after edge M+1.
- The router registers each request. `dvld` and the tags are the request valid and request fields delayed by exactly one cycle. This is a fixed latency of 1 with no backpressure.
- Back-to-back requests have no bubbles inside a sweep. There is exactly one idle-bus cycle minimum between sweeps (the WAIT state).
- `done` is asserted in the cycle after the last `dvld`.
- Asynchronous `rst_n` assertion mid-sweep: outputs return to reset values immediately and the in-flight `dvld` is discarded.

## Configuration
- `DATA_ROUTER_REQ_STRIDE_EN` defined: the RP column step is `STRIDE`.
- Undefined: the RP step is fixed at 1, the `STRIDE` parameter is ignored, and the stride logic is removed.

## Test plan
- Reset, then `start`, mode=00, nblk=1, then `blkend` 10 cycles later:
  - Requests RR with rows 0,1,2 on consecutive cycles.
  - `dvld` 3 cycles, tags rows 0..2, each one cycle later.
  - `done` pulses 1 cycle after the last `dvld`.
- mode=01, nblk=2, two `blkend` pulses 100 cycles apart:
  - 9 BR requests per block, order bank0 row0..2, bank1.., bank2..
  - 18 `dvld` total, one `done`.
- mode=10 with STRIDE=2 and the macro defined:
  - 3 rows x 16 cols (0,2..30), 48 requests.
  - With the macro undefined: 96 requests, cols 0..31.
- `blkend` during block 1 ISSUE with nblk=2:
  - Block 2 starts after exactly one WAIT cycle.
  - A third `blkend` in the same window sets `err[1]`; the sweep counts are otherwise unchanged.
- `start` with mode=11:
  - `err[0]` = 1, `busy` stays 0.
  - A following legal `start` clears `err` and runs normally.
- `rst_n` pulsed low in mid-RP sweep:
  - All outputs are 0 within the reset cycle.
  - A new `start` after release runs a full, correct sweep.
